// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller for a word-wide data memory
// Handles sub-word loads with extension and sub-word stores via read-modify-write.
module lsu_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

  state_t              state, state_nx;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         merge_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic                accept;
  logic                req_err;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_data;
  logic [31:0]         st_merge;

  assign accept  = req_valid && (state == S_IDLE);
  assign req_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                state_nx = S_RESP;
          else if (!req_we)           state_nx = S_LOAD;
          else if (req_size == 2'b10) state_nx = S_WRITE;
          else                        state_nx = S_RMW_RD;
        end
      end
      S_LOAD:   state_nx = S_RESP;
      S_RMW_RD: state_nx = S_WRITE;
      S_WRITE:  state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    ld_byte = dm_dout[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_data = dm_dout;
    endcase
    st_merge = dm_dout;
    if (size_q == 2'b00) st_merge[{addr_q[1:0], 3'b000} +: 8] = merge_q[7:0];
    else                 st_merge[{addr_q[1], 4'b0000} +: 16] = merge_q[15:0];
  end

  // merge_q holds raw store data until RMW_RD overwrites it with the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        size_q  <= req_size;
        sgn_q   <= req_signed;
        addr_q  <= req_addr;
        merge_q <= req_wdata;
        rdata_q <= 32'h0;
        err_q   <= req_err;
      end
      if (state == S_LOAD)   rdata_q <= ld_data;
      if (state == S_RMW_RD) merge_q <= st_merge;
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_din     = 32'h0;
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_LOAD, S_RMW_RD: dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
      S_WRITE: begin
        dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
        dm_din  = merge_q;
        dm_we   = 1'b1;
      end
      S_RESP:  resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed and randomized checks of lsu_ctrl against a memory-level model
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  bit   [31:0] mem     [256];
  bit   [31:0] ref_mem [256];

  int checks   = 0;
  int failures = 0;
  int last_waits;

  lsu_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, "_rvalid"}, {31'h0, resp_valid}, 32'h0);
    check({tag, "_rdata"}, resp_rdata, 32'h0);
    check({tag, "_err"}, {31'h0, resp_err}, 32'h0);
    check({tag, "_dmwe"}, {31'h0, dm_we}, 32'h0);
    check({tag, "_dmaddr"}, {22'h0, dm_addr}, 32'h0);
    check({tag, "_dmdin"}, dm_din, 32'h0);
  endtask

  // Called at #1 after a rising edge with the DUT idle (or in RESP when the
  // previous request was held valid). Returns at the RESP sample point.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [9:0] a, input logic [31:0] wd, input bit hold);
    logic [31:0] w, v, nw, exp_rdata;
    logic        exp_err;
    int          exp_lat, sh, lat, we_cnt, we_lat;
    logic [31:0] we_din;
    logic [9:0]  we_addr;
    bit          done;

    w  = ref_mem[a[9:2]];
    sh = int'(a[1:0]) * 8;
    nw = w;
    exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_rdata = 32'h0;
    if (exp_err) exp_lat = 1;
    else if (!we) begin
      exp_lat = 2;
      if (sz == 2'b00) begin
        v = (w >> sh) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
        v = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF0000;
      end else v = w;
      exp_rdata = v;
    end else if (sz == 2'b10) begin
      exp_lat = 2;
      nw = wd;
    end else begin
      exp_lat = 3;
      if (sz == 2'b00) nw = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      else if (a[1])   nw = (w & 32'h0000FFFF) | ((wd & 32'hFFFF) << 16);
      else             nw = (w & 32'hFFFF0000) | (wd & 32'hFFFF);
    end

    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    last_waits = 0;
    while (!req_ready && last_waits < 8) begin
      @(posedge clk); #1;
      last_waits++;
    end
    check("accept_ready", {31'h0, req_ready}, 32'h1);

    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    lat = 1; we_cnt = 0; we_lat = 0; we_din = 0; we_addr = 0; done = 0;
    while (!done && lat <= 6) begin
      if (dm_we) begin
        we_cnt++; we_lat = lat; we_din = dm_din; we_addr = dm_addr;
      end
      if (resp_valid) done = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end

    check("latency", lat, exp_lat);
    check("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
    check("resp_rdata", resp_rdata, exp_rdata);
    check("we_count", we_cnt, (we && !exp_err) ? 1 : 0);
    if (we && !exp_err) begin
      check("we_cycle", we_lat, exp_lat - 1);
      check("we_din", we_din, nw);
      check("we_addr", {22'h0, we_addr}, {22'h0, a[9:2], 2'b00});
    end
    check("resp_dmaddr", {22'h0, dm_addr}, 32'h0);
    check("resp_dmdin", dm_din, 32'h0);
    ref_mem[a[9:2]] = nw;
    check("mem_word", mem[a[9:2]], ref_mem[a[9:2]]);

    if (!hold) begin
      @(posedge clk); #1;
      check("post_rvalid", {31'h0, resp_valid}, 32'h0);
      check("post_ready", {31'h0, req_ready}, 32'h1);
      check("hold_rdata", resp_rdata, exp_rdata);
      check("hold_err", {31'h0, resp_err}, {31'h0, exp_err});
    end
  endtask

  initial begin
    int bad_we, bad_rv;
    logic [1:0] sz;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // Sub-word loads with sign extension.
    issue(1'b1, 2'b10, 1'b0, 10'h008, 32'h11223344, 0);
    issue(1'b0, 2'b00, 1'b1, 10'h00B, 32'h0, 0);
    check("lb_signed_0xB", resp_rdata, 32'h00000011);
    issue(1'b1, 2'b10, 1'b0, 10'h008, 32'h80FF0000, 0);
    issue(1'b0, 2'b01, 1'b1, 10'h00A, 32'h0, 0);
    check("lh_signed_0xA", resp_rdata, 32'hFFFF80FF);
    issue(1'b0, 2'b01, 1'b0, 10'h00A, 32'h0, 0);
    check("lhu_0xA", resp_rdata, 32'h000080FF);

    // Byte store read-modify-write.
    issue(1'b1, 2'b10, 1'b0, 10'h004, 32'hAABBCCDD, 0);
    issue(1'b1, 2'b00, 1'b0, 10'h005, 32'h000000EE, 0);
    check("sb_merged", mem[1], 32'hAABBEEDD);

    // Misaligned and illegal-size requests.
    issue(1'b1, 2'b10, 1'b0, 10'h006, 32'hDEADBEEF, 0);
    issue(1'b0, 2'b11, 1'b0, 10'h000, 32'h0, 0);
    issue(1'b1, 2'b01, 1'b0, 10'h003, 32'h1234, 0);

    // Back-to-back with req_valid held through RESP.
    issue(1'b1, 2'b10, 1'b0, 10'h010, 32'h12345678, 1);
    issue(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 0);
    check("b2b_waits", last_waits, 1);
    check("b2b_rdata", resp_rdata, 32'h12345678);

    // Randomized traffic over a small window so loads hit earlier stores.
    for (int i = 0; i < 250; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) != 0 && sz == 2'b11) sz = 2'b10;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            10'($urandom_range(0, 63)), $urandom, 0);
    end

    // Reset during RMW_RD of a halfword store must not write memory.
    issue(1'b1, 2'b10, 1'b0, 10'h000, 32'hCAFEF00D, 0);
    req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 10'h002;
    req_wdata = 32'h00005555; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort_reset");
    bad_we = 0; bad_rv = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (dm_we) bad_we++;
      if (resp_valid) bad_rv++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (dm_we) bad_we++;
      if (resp_valid) bad_rv++;
    end
    check("abort_no_we", bad_we, 0);
    check("abort_no_resp", bad_rv, 0);
    check_idle_outputs("abort_release");
    check("abort_mem", mem[0], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of the data-memory port.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed  input  1  sign-extend sub-word loads; ignored for stores/word.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned/illegal request, valid with resp_valid.
REQ-014 SHALL have port dm_addr  output  ADDR_W  word-aligned address to data memory (low 2 bits 0).
REQ-015 SHALL have port dm_din  output  32  write word to data memory.
REQ-016 SHALL have port dm_we  output  1  data-memory write enable, sampled by memory on rising clk.
REQ-017 SHALL have port dm_dout  input  32  combinational read word from data memory at dm_addr.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL accept on req_valid & req_ready, latching we, size, signed, addr, wdata.
REQ-020 SHALL flag error when size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 00.
REQ-021 SHALL on error go IDLE -> RESP with resp_err = 1, resp_rdata = 0, no dm_we; latency 1 cycle (accept edge to resp_valid).
REQ-022 SHALL on load go IDLE -> LOAD -> RESP; in LOAD drive dm_addr and register extracted data; latency 2 cycles.
REQ-023 SHALL on word store go IDLE -> WRITE -> RESP; latency 2 cycles.
REQ-024 SHALL on byte/half store go IDLE -> RMW_RD -> WRITE -> RESP; RMW_RD registers dm_dout with the addressed lanes replaced; latency 3 cycles.
REQ-025 SHALL use little-endian lanes: byte k (addr[1:0] = k) is bits 8k+7:8k; halfword addr[1] selects bits 31:16 (1) or 15:0 (0).
REQ-026 SHALL zero-extend sub-word loads when req_signed = 0 and sign-extend from lane MSB when 1.
REQ-027 SHALL assert dm_we only in WRITE, for exactly one cycle per store, with dm_din = full merged word.
REQ-028 SHALL drive dm_addr = 0 and dm_din = 0 in IDLE and RESP.
REQ-029 SHALL assert resp_valid only in RESP, exactly one cycle, then return to IDLE; no response backpressure.
REQ-030 SHALL ignore req_valid outside IDLE; a request held valid across RESP is accepted the cycle after RESP.
REQ-031 SHALL hold resp_rdata/resp_err stable from RESP until next acceptance.

Reset
REQ-032 SHALL on rst_n = 0 immediately enter IDLE and force req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, dm_we = 0, dm_addr = 0, dm_din = 0.
REQ-033 SHALL abort any in-flight request on reset without response; a reset asserted during RMW_RD or WRITE SHALL produce no memory write after its assertion.

Verification
REQ-034 SHALL pass: memory word 0x8 = 0x11223344; lb signed addr 0xB -> resp_rdata 0x00000011 at accept+2; lh signed addr 0xA with word 0x80FF0000 -> 0xFFFF80FF.
REQ-035 SHALL pass: word 0x4 = 0xAABBCCDD; sb addr 0x5 wdata 0x000000EE -> single dm_we pulse at accept+2 with dm_din 0xAABBEEDD, resp_valid at accept+3.
REQ-036 SHALL pass: sw addr 0x6 -> resp_err = 1 at accept+1, resp_rdata 0, dm_we never asserted; req_size 11 likewise errors.
REQ-037 SHALL pass: back-to-back sw 0x10 = 0x12345678 then lw 0x10 with req_valid held high -> second accepted the cycle after first RESP, returns 0x12345678.
REQ-038 SHALL pass: rst_n low during RMW_RD of sh addr 0x2 -> no dm_we, no resp_valid, outputs at reset values, req_ready = 1 after release.
